// File: rtl/unidad_procesadora_pipe.sv
`default_nettype none
// ============================================================================
// Module   : unidad_procesadora_pipe
// Brief    : two-stage pipelined register file + ALU/shifter datapath; define
//            FWD_EN to forward the EX result instead of stalling on a hazard.
// Revision : 1.0
// ============================================================================
module unidad_procesadora_pipe #(
    parameter  int M    = 8,
    parameter  int NREG = 8,
    localparam int SW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cw_valid,
    output logic          cw_ready,
    input  logic [SW-1:0] A_sel,
    input  logic [SW-1:0] B_sel,
    input  logic [SW-1:0] Dest_sel,
    input  logic [3:0]    G_sel,
    input  logic [1:0]    H_sel,
    input  logic          MB_sel,
    input  logic          MF_sel,
    input  logic          MD_sel,
    input  logic          Load_en,
    input  logic [M-1:0]  Cons_IN,
    input  logic [M-1:0]  Data_IN,
    output logic [M-1:0]  Address_out,
    output logic [M-1:0]  Data_out,
    output logic [M-1:0]  Reg_in,
    output logic          res_valid,
    output logic [3:0]    Tags
);

    localparam logic [M:0] c_ONE = (M+1)'(1);

    logic [M-1:0]  rf_q [NREG];

    logic          ex_valid_q;
    logic [M-1:0]  ex_a_q;
    logic [M-1:0]  ex_b_q;
    logic [M-1:0]  ex_din_q;
    logic [3:0]    ex_g_q;
    logic [1:0]    ex_h_q;
    logic          ex_mf_q;
    logic          ex_md_q;
    logic          ex_load_q;
    logic [SW-1:0] ex_dest_q;

    logic [M-1:0]  reg_in_q;
    logic [3:0]    tags_q;
    logic          res_valid_q;

    logic [M:0]    w_sum;
    logic          w_v;
    logic [M-1:0]  w_nb;
    logic [M-1:0]  w_shift;
    logic [M-1:0]  w_result;
    logic [3:0]    tags_d;
    logic          w_haz_a;
    logic          w_haz_b;
    logic [M-1:0]  w_opa;
    logic [M-1:0]  w_rfb;
    logic [M-1:0]  w_opb;
    logic          w_accept;

    // ALU: M+1-bit arithmetic so bit M is the carry/borrow; logic ops leave it 0
    assign w_nb = ~ex_b_q;

    always_comb begin
        w_sum = {1'b0, ex_a_q};
        w_v   = 1'b0;
        casez (ex_g_q)
            4'b0001: begin
                w_sum = {1'b0, ex_a_q} + c_ONE;
                w_v   = ~ex_a_q[M-1] & w_sum[M-1];
            end
            4'b0010: begin
                w_sum = {1'b0, ex_a_q} + {1'b0, ex_b_q};
                w_v   = (ex_a_q[M-1] == ex_b_q[M-1]) & (w_sum[M-1] != ex_a_q[M-1]);
            end
            4'b0011: begin
                w_sum = {1'b0, ex_a_q} + {1'b0, ex_b_q} + c_ONE;
                w_v   = (ex_a_q[M-1] == ex_b_q[M-1]) & (w_sum[M-1] != ex_a_q[M-1]);
            end
            4'b0100: begin
                w_sum = {1'b0, ex_a_q} + {1'b0, w_nb};
                w_v   = (ex_a_q[M-1] == w_nb[M-1]) & (w_sum[M-1] != ex_a_q[M-1]);
            end
            4'b0101: begin
                w_sum = {1'b0, ex_a_q} - {1'b0, ex_b_q};
                w_v   = (ex_a_q[M-1] != ex_b_q[M-1]) & (w_sum[M-1] != ex_a_q[M-1]);
            end
            4'b0110: begin
                w_sum = {1'b0, ex_a_q} - c_ONE;
                w_v   = ex_a_q[M-1] & ~w_sum[M-1];
            end
            4'b1000: w_sum = {1'b0, ex_a_q & ex_b_q};
            4'b1001: w_sum = {1'b0, ex_a_q | ex_b_q};
            4'b1010: w_sum = {1'b0, ex_a_q ^ ex_b_q};
            4'b1011: w_sum = {1'b0, ~ex_a_q};
            4'b11??: w_sum = {1'b0, ex_b_q};
            default: w_sum = {1'b0, ex_a_q};
        endcase
    end

    assign tags_d = {w_v, w_sum[M], w_sum[M-1], ~|w_sum[M-1:0]};

    always_comb begin
        case (ex_h_q)
            2'b00:   w_shift = ex_b_q;
            2'b01:   w_shift = {1'b0, ex_b_q[M-1:1]};
            2'b10:   w_shift = {ex_b_q[M-2:0], 1'b0};
            default: w_shift = {ex_b_q[0], ex_b_q[M-1:1]};
        endcase
    end

    assign w_result = ex_md_q ? ex_din_q : (ex_mf_q ? w_shift : w_sum[M-1:0]);

    // Read-after-write against the word currently in EX
    assign w_haz_a = ex_valid_q & ex_load_q & (A_sel == ex_dest_q);
    assign w_haz_b = ex_valid_q & ex_load_q & ~MB_sel & (B_sel == ex_dest_q);

`ifdef FWD_EN
    assign cw_ready = 1'b1;
    assign w_opa    = w_haz_a ? w_result : rf_q[A_sel];
    assign w_rfb    = w_haz_b ? w_result : rf_q[B_sel];
`else
    assign cw_ready = ~(cw_valid & (w_haz_a | w_haz_b));
    assign w_opa    = rf_q[A_sel];
    assign w_rfb    = rf_q[B_sel];
`endif

    assign w_opb    = MB_sel ? Cons_IN : w_rfb;
    assign w_accept = cw_valid & cw_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_din_q    <= '0;
            ex_g_q      <= '0;
            ex_h_q      <= '0;
            ex_mf_q     <= 1'b0;
            ex_md_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_dest_q   <= '0;
            reg_in_q    <= '0;
            tags_q      <= '0;
            res_valid_q <= 1'b0;
        end else begin
            ex_valid_q  <= w_accept;
            res_valid_q <= ex_valid_q;
            if (w_accept) begin
                ex_a_q    <= w_opa;
                ex_b_q    <= w_opb;
                ex_din_q  <= Data_IN;
                ex_g_q    <= G_sel;
                ex_h_q    <= H_sel;
                ex_mf_q   <= MF_sel;
                ex_md_q   <= MD_sel;
                ex_load_q <= Load_en;
                ex_dest_q <= Dest_sel;
            end
            if (ex_valid_q) begin
                reg_in_q <= w_result;
                if (!ex_mf_q && !ex_md_q) begin
                    tags_q <= tags_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (ex_valid_q && ex_load_q) begin
            rf_q[ex_dest_q] <= w_result;
        end
    end

    assign Address_out = ex_a_q;
    assign Data_out    = ex_b_q;
    assign Reg_in      = reg_in_q;
    assign Tags        = tags_q;
    assign res_valid   = res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_unidad_procesadora_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidad_procesadora_pipe
// Brief    : directed bench for unidad_procesadora_pipe with an architectural
//            reference model (honours FWD_EN).
// Revision : 1.0
// ============================================================================
module tb_unidad_procesadora_pipe;

    localparam int M    = 8;
    localparam int NREG = 8;
    localparam int SW   = 3;
    localparam int MASK = (1 << M) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cw_valid;
    logic          cw_ready;
    logic [SW-1:0] A_sel, B_sel, Dest_sel;
    logic [3:0]    G_sel;
    logic [1:0]    H_sel;
    logic          MB_sel, MF_sel, MD_sel, Load_en;
    logic [M-1:0]  Cons_IN, Data_IN;
    logic [M-1:0]  Address_out, Data_out, Reg_in;
    logic          res_valid;
    logic [3:0]    Tags;

    unidad_procesadora_pipe #(.M(M), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n), .cw_valid(cw_valid), .cw_ready(cw_ready),
        .A_sel(A_sel), .B_sel(B_sel), .Dest_sel(Dest_sel), .G_sel(G_sel),
        .H_sel(H_sel), .MB_sel(MB_sel), .MF_sel(MF_sel), .MD_sel(MD_sel),
        .Load_en(Load_en), .Cons_IN(Cons_IN), .Data_IN(Data_IN),
        .Address_out(Address_out), .Data_out(Data_out), .Reg_in(Reg_in),
        .res_valid(res_valid), .Tags(Tags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- architectural reference model ----------------
    int mreg [NREG];
    int p_valid = 0, p_a = 0, p_b = 0, p_din = 0, p_g = 0, p_h = 0;
    int p_mf = 0, p_md = 0, p_load = 0, p_dest = 0;
    int e_addr = 0, e_data = 0, e_regin = 0, e_tags = 0, e_rv = 0;

    function automatic int sgn(input int x);
        return (x >= (1 << (M-1))) ? x - (1 << M) : x;
    endfunction

    task automatic model_alu(input int g, input int a, input int b,
                             output int r, output int c, output int v);
        int u, s, arith;
        arith = 1;
        s = 0;
        case (g)
            1:  begin u = a + 1;            s = sgn(a) + 1; end
            2:  begin u = a + b;            s = sgn(a) + sgn(b); end
            3:  begin u = a + b + 1;        s = sgn(a) + sgn(b) + 1; end
            4:  begin u = a + (MASK - b);   s = sgn(a) + sgn(MASK - b); end
            5:  begin u = a - b;            s = sgn(a) - sgn(b); end
            6:  begin u = a - 1;            s = sgn(a) - 1; end
            8:  begin u = a & b;            arith = 0; end
            9:  begin u = a | b;            arith = 0; end
            10: begin u = a ^ b;            arith = 0; end
            11: begin u = MASK - a;         arith = 0; end
            12, 13, 14, 15: begin u = b;    arith = 0; end
            default: begin u = a;           arith = 0; end
        endcase
        r = u & MASK;
        c = arith ? ((u >> M) & 1) : 0;
        v = (arith != 0 && (s > (1 << (M-1)) - 1 || s < -(1 << (M-1)))) ? 1 : 0;
    endtask

    function automatic int model_shift(input int b, input int h);
        case (h)
            1:       return b / 2;
            2:       return (b * 2) & MASK;
            3:       return b / 2 + (b % 2) * (1 << (M-1));
            default: return b;
        endcase
    endfunction

    function automatic int model_ready();
`ifdef FWD_EN
        return 1;
`else
        if (cw_valid && p_valid != 0 && p_load != 0 &&
            (int'(A_sel) == p_dest || (!MB_sel && int'(B_sel) == p_dest)))
            return 0;
        return 1;
`endif
    endfunction

    // A word reads the register file as it stands after the older word's write
    task automatic model_step();
        int r, c, v, res, acc;
        if (!rst_n) begin
            foreach (mreg[i]) mreg[i] = 0;
            p_valid = 0; e_addr = 0; e_data = 0; e_regin = 0; e_tags = 0; e_rv = 0;
            return;
        end
        acc = (cw_valid && model_ready() != 0) ? 1 : 0;
        if (p_valid != 0) begin
            model_alu(p_g, p_a, p_b, r, c, v);
            res = (p_md != 0) ? p_din : ((p_mf != 0) ? model_shift(p_b, p_h) : r);
            if (p_load != 0) mreg[p_dest] = res;
            e_regin = res;
            if (p_mf == 0 && p_md == 0)
                e_tags = v * 8 + c * 4 + ((r >> (M-1)) & 1) * 2 + ((r == 0) ? 1 : 0);
            e_rv = 1;
        end else begin
            e_rv = 0;
        end
        if (acc != 0) begin
            p_a    = mreg[A_sel];
            p_b    = MB_sel ? int'(Cons_IN) : mreg[B_sel];
            p_din  = int'(Data_IN);
            p_g    = int'(G_sel);
            p_h    = int'(H_sel);
            p_mf   = int'(MF_sel);
            p_md   = int'(MD_sel);
            p_load = int'(Load_en);
            p_dest = int'(Dest_sel);
            e_addr = p_a;
            e_data = p_b;
        end
        p_valid = acc;
    endtask

    initial begin
        foreach (mreg[i]) mreg[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("cw_ready",    int'(cw_ready),    model_ready());
            chk("res_valid",   int'(res_valid),   e_rv);
            chk("Address_out", int'(Address_out), e_addr);
            chk("Data_out",    int'(Data_out),    e_data);
            chk("Reg_in",      int'(Reg_in),      e_regin);
            chk("Tags",        int'(Tags),        e_tags);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int a, input int b, input int d, input int g, input int h,
                         input int mb, input int mf, input int md, input int ld,
                         input int cons, input int din, output int stalls);
        A_sel = SW'(a); B_sel = SW'(b); Dest_sel = SW'(d);
        G_sel = 4'(g); H_sel = 2'(h);
        MB_sel = 1'(mb); MF_sel = 1'(mf); MD_sel = 1'(md); Load_en = 1'(ld);
        Cons_IN = M'(cons); Data_IN = M'(din);
        cw_valid = 1'b1;
        stalls = 0;
        #2;
        while (!cw_ready && stalls < 8) begin
            @(negedge clk);
            #2;
            stalls++;
        end
        chk("issue_ready", int'(cw_ready), 1);
        @(posedge clk);
        @(negedge clk);
        cw_valid = 1'b0;
    endtask

    task automatic expect_res(input string nm, input int val);
        @(negedge clk);
        chk({nm, "_regin"}, int'(Reg_in), val);
        chk({nm, "_rv"}, int'(res_valid), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d)", passes, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int st, exp_st;
`ifdef FWD_EN
        exp_st = 0;
`else
        exp_st = 1;
`endif
        rst_n = 1'b0;
        cw_valid = 1'b1;
        A_sel = 3'd1; B_sel = 3'd2; Dest_sel = 3'd1; G_sel = 4'd2; H_sel = 2'd0;
        MB_sel = 1'b0; MF_sel = 1'b0; MD_sel = 1'b1; Load_en = 1'b1;
        Cons_IN = 8'h33; Data_IN = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_Reg_in", int'(Reg_in), 0);
        chk("rst_Tags", int'(Tags), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_cw_ready", int'(cw_ready), 1);
        chk("rst_Address_out", int'(Address_out), 0);
        rst_n = 1'b1;
        cw_valid = 1'b0;

        for (int i = 0; i < NREG; i++) begin
            issue(i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
            chk("rd_zero_addr", int'(Address_out), 0);
        end
        @(negedge clk);

        // load/add
        issue(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 'h5A, st);
        issue(0, 0, 2, 0, 0, 0, 0, 1, 1, 0, 'h0F, st);
        chk("b2b_stalls", st, 0);
        issue(1, 2, 3, 2, 0, 0, 0, 0, 1, 0, 0, st);
        chk("addB_stalls", st, exp_st);
        chk("add_addr", int'(Address_out), 'h5A);
        chk("add_data", int'(Data_out), 'h0F);
        expect_res("add", 'h69);
        chk("add_tags", int'(Tags), 0);
        issue(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        expect_res("rd_r3", 'h69);

        // flags
        issue(0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 'h7F, st);
        issue(5, 0, 0, 2, 0, 1, 0, 0, 0, 'h01, 0, st);
        expect_res("ovf", 'h80);
        chk("ovf_tags", int'(Tags), 'hA);
        issue(0, 0, 6, 0, 0, 0, 0, 1, 1, 0, 'hFF, st);
        issue(6, 0, 0, 2, 0, 1, 0, 0, 0, 'h01, 0, st);
        expect_res("carry", 'h00);
        chk("carry_tags", int'(Tags), 'h5);

        // shifter, tags must hold
        issue(0, 0, 0, 0, 3, 1, 1, 0, 0, 'h81, 0, st);
        expect_res("ror", 'hC0);
        chk("ror_tags", int'(Tags), 'h5);
        issue(0, 0, 0, 0, 1, 1, 1, 0, 0, 'h81, 0, st);
        expect_res("lsr", 'h40);
        issue(0, 0, 0, 0, 2, 1, 1, 0, 0, 'h81, 0, st);
        expect_res("lsl", 'h02);
        chk("shift_tags", int'(Tags), 'h5);

        // subtract with borrow: 0x0F - 0x5A
        issue(2, 0, 0, 5, 0, 1, 0, 0, 0, 'h5A, 0, st);
        expect_res("sub", 'hB5);
        chk("sub_tags", int'(Tags), 'h6);

        // all ALU codes, constant and register B, back to back
        for (int g = 0; g < 16; g++) begin
            issue(5, 6, 0, g, 0, 1, 0, 0, 0, 'h80, 0, st);
            issue(5, 6, 0, g, 0, 0, 0, 0, 0, 0, 0, st);
        end
        @(negedge clk);

        // destination equals source
        issue(1, 0, 1, 1, 0, 1, 0, 0, 1, 'h01, 0, st);
        issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        expect_res("self_upd", 'h5B);

        // hazard
        issue(0, 0, 3, 0, 0, 0, 0, 1, 1, 0, 'h10, st);
        issue(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, st);
        chk("haz_stalls", st, exp_st);
        expect_res("haz", 'h11);

        // reset mid-operation
        issue(0, 0, 4, 0, 0, 0, 0, 1, 1, 0, 'hAA, st);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rv", int'(res_valid), 0);
        chk("midrst_regin", int'(Reg_in), 0);
        issue(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        expect_res("midrst_r4", 'h00);
        issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        expect_res("midrst_r1", 'h00);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
